pc_ir_unit: RTL and testbench
=============================

PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Ports, clock and reset first:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCWrite  in  1  unconditional PC write enable, from control.
- PCWriteCond  in  1  PC write enable qualified by zero, from control.
- IRWrite  in  1  instruction register load enable, from control.
- PCSource  in  2  next-PC select, from control.
- zero  in  1  ALU zero flag.
- alu_result  in  32  combinational ALU output.
- mem_data  in  32  memory read data.
- pc  out  32  current program counter.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26], drives the control FSM.
- rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- funct  out  6  ir[5:0].
- imm_sext  out  32  ir[15:0] sign-extended.
- mdr  out  32  memory data register.
- alu_out  out  32  registered ALU result (ALUOut).
- halted  out  1  sticky halt indication.
- misaligned  out  1  sticky: a PC write with nonzero bits [1:0] was attempted.
- instr_count  out  32  number of IR loads since reset.

Function
REQ-003 alu_out SHALL capture alu_result every cycle; mdr SHALL capture mem_data every cycle.
REQ-004 pc_en SHALL be (PCWrite | (PCWriteCond & zero)) & ~halted & ~misaligned.
REQ-005 Next-PC SHALL be: 2'b00 alu_result; 2'b01 alu_out; 2'b10 {pc[31:28], ir[25:0], 2'b00}; 2'b11 pc (hold).
REQ-006 On pc_en with candidate[1:0] != 0, pc SHALL hold and misaligned SHALL set next edge; otherwise pc SHALL load the candidate.
REQ-007 PCWrite and PCWriteCond both high SHALL behave as PCWrite alone; PCWriteCond with zero=0 SHALL leave pc unchanged.
REQ-008 ir SHALL load mem_data on IRWrite & ~halted; otherwise hold.
REQ-009 instr_count SHALL increment by 1 on each ir load and saturate at 32'hFFFFFFFF.
REQ-010 halted SHALL set on the edge after ir holds opcode 6'b111111 and stay set until reset; while set, pc, ir, instr_count SHALL freeze; alu_out and mdr continue updating.
REQ-011 Decoded fields (opcode, rs, rt, rd, funct, imm_sext) SHALL be combinational from ir, zero latency.
REQ-012 An IR load and PC write in the same cycle SHALL both take effect, the jump target using the pre-edge ir.

Reset
REQ-013 On rst high, immediately and independent of clk: pc=RESET_PC, ir=0, mdr=0, alu_out=0, instr_count=0, halted=0, misaligned=0.
REQ-014 Reset asserted mid-instruction SHALL discard all state; first edge after release resumes normal updates.

Structure
REQ-015 Shared package cpu_pkg SHALL hold opcode constants (RTYPE, LW, SW, BEQ, J, HALT) and PCSource encodings (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_HOLD).
REQ-016 One sub-module, pc_next_sel, SHALL implement REQ-004 to REQ-006 next-PC selection and alignment check combinationally; registers stay in pc_ir_unit.

Verification
REQ-017 Fetch: RESET_PC=0, PCWrite=1, IRWrite=1, PCSource=00, alu_result=4, mem_data=32'h8C010004 -> pc=4, ir=32'h8C010004, opcode=6'b100011, instr_count=1.
REQ-018 Branch: PCWriteCond=1, PCSource=01, alu_out=32'h40; zero=0 -> pc unchanged; zero=1 -> pc=32'h40.
REQ-019 Jump: pc=32'h10000008, ir=32'h08000010, PCWrite=1, PCSource=10 -> pc=32'h10000040.
REQ-020 Halt: load ir=32'hFC000000 -> halted=1 next edge; further PCWrite/IRWrite leave pc, ir, instr_count unchanged.
REQ-021 Misaligned: PCWrite=1, PCSource=00, alu_result=32'h6 -> pc holds, misaligned=1, later writes ignored.
REQ-022 Async reset: assert rst between edges during halt -> all outputs at reset values before next edge, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, next-PC select encodings and
// small decode helpers used by the fetch/decode datapath.
package cpu_pkg;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] HALT  = 6'b111111;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Word alignment check for PC candidates
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: computes the write enable, the candidate PC and
// whether the candidate may be loaded or instead flags a misalignment.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        zero,
    input  logic        halted,
    input  logic        misaligned,
    input  logic [1:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] pc,
    input  logic [25:0] jump_index,
    output logic [31:0] pc_cand,
    output logic        pc_load,
    output logic        misalign_set
);

    logic pc_en_s;

    // Select the candidate next PC from the requested source
    always_comb begin
        pc_cand = pc;
        case (pc_source)
            PCSRC_ALU:    pc_cand = alu_result;
            PCSRC_ALUOUT: pc_cand = alu_out;
            PCSRC_JUMP:   pc_cand = {pc[31:28], jump_index, 2'b00};
            PCSRC_HOLD:   pc_cand = pc;
            default:      pc_cand = pc;
        endcase
    end

    // Qualify the write and split it into a load or a misalignment flag
    always_comb begin
        pc_en_s      = (pc_write | (pc_write_cond & zero)) & ~halted & ~misaligned;
        pc_load      = 1'b0;
        misalign_set = 1'b0;
        if (pc_en_s) begin
            if (is_word_aligned(pc_cand)) begin
                pc_load = 1'b1;
            end else begin
                misalign_set = 1'b1;
            end
        end else begin
            pc_load      = 1'b0;
            misalign_set = 1'b0;
        end
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter and instruction register unit of a multicycle CPU:
// holds PC, IR, MDR, ALUOut, halt/misalignment status and an IR load count.
module pc_ir_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        IRWrite,
    input  logic [1:0]  PCSource,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [31:0] imm_sext,
    output logic [31:0] mdr,
    output logic [31:0] alu_out,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] instr_count
);

    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] mdr_r;
    logic [31:0] alu_out_r;
    logic        halted_r;
    logic        misaligned_r;
    logic [31:0] instr_count_r;

    logic [31:0] pc_cand_s;
    logic        pc_load_s;
    logic        misalign_set_s;
    logic        ir_load_s;

    pc_next_sel u_pc_next_sel (
        .pc_write      (PCWrite),
        .pc_write_cond (PCWriteCond),
        .zero          (zero),
        .halted        (halted_r),
        .misaligned    (misaligned_r),
        .pc_source     (PCSource),
        .alu_result    (alu_result),
        .alu_out       (alu_out_r),
        .pc            (pc_r),
        .jump_index    (ir_r[25:0]),
        .pc_cand       (pc_cand_s),
        .pc_load       (pc_load_s),
        .misalign_set  (misalign_set_s)
    );

    assign ir_load_s = IRWrite & ~halted_r;

    // Program counter and sticky misalignment flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            misaligned_r <= 1'b0;
        end else begin
            if (pc_load_s) begin
                pc_r <= pc_cand_s;
            end
            if (misalign_set_s) begin
                misaligned_r <= 1'b1;
            end
        end
    end

    // Instruction register and saturating load counter; the jump target
    // above always sees the pre-edge IR even when both load together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_r          <= 32'h0000_0000;
            instr_count_r <= 32'h0000_0000;
        end else if (ir_load_s) begin
            ir_r <= mem_data;
            if (instr_count_r != 32'hFFFF_FFFF) begin
                instr_count_r <= instr_count_r + 32'd1;
            end
        end
    end

    // Free-running capture of memory data and ALU result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdr_r     <= 32'h0000_0000;
            alu_out_r <= 32'h0000_0000;
        end else begin
            mdr_r     <= mem_data;
            alu_out_r <= alu_result;
        end
    end

    // Sticky halt, set one edge after a HALT opcode sits in IR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if (ir_r[31:26] == HALT) begin
            halted_r <= 1'b1;
        end
    end

    assign pc          = pc_r;
    assign ir          = ir_r;
    assign mdr         = mdr_r;
    assign alu_out     = alu_out_r;
    assign halted      = halted_r;
    assign misaligned  = misaligned_r;
    assign instr_count = instr_count_r;

    assign opcode   = ir_r[31:26];
    assign rs       = ir_r[25:21];
    assign rt       = ir_r[20:16];
    assign rd       = ir_r[15:11];
    assign funct    = ir_r[5:0];
    assign imm_sext = sext16(ir_r[15:0]);

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios followed by
// randomized cycles compared against a behavioural model.
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, PCWriteCond, IRWrite, zero;
    logic [1:0]  PCSource;
    logic [31:0] alu_result, mem_data;
    logic [31:0] pc, ir, imm_sext, mdr, alu_out, instr_count;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic        halted, misaligned;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_ir, m_mdr, m_alu_out, m_count;
    logic        m_halted, m_mis;

    pc_ir_unit dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IRWrite(IRWrite), .PCSource(PCSource), .zero(zero),
        .alu_result(alu_result), .mem_data(mem_data), .pc(pc), .ir(ir),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
        .imm_sext(imm_sext), .mdr(mdr), .alu_out(alu_out), .halted(halted),
        .misaligned(misaligned), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_alu_out = 32'h0;
        m_count = 32'h0; m_halted = 1'b0; m_mis = 1'b0;
    endtask

    // One clock edge of the architectural rules, from pre-edge state
    task automatic model_step();
        logic [31:0] cand, n_pc, n_ir, n_count;
        logic        n_mis, n_halt, wr;
        case (PCSource)
            2'd0: cand = alu_result;
            2'd1: cand = m_alu_out;
            2'd2: cand = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
            default: cand = m_pc;
        endcase
        wr = (PCWrite || (PCWriteCond && zero)) && !m_halted && !m_mis;
        n_pc = m_pc; n_mis = m_mis; n_ir = m_ir; n_count = m_count;
        if (wr) begin
            if (cand % 32'd4 != 32'd0) n_mis = 1'b1;
            else n_pc = cand;
        end
        if (IRWrite && !m_halted) begin
            n_ir = mem_data;
            if (m_count != 32'hFFFF_FFFF) n_count = m_count + 32'd1;
        end
        n_halt = m_halted || ((m_ir >> 26) == 32'd63);
        m_pc = n_pc; m_mis = n_mis; m_ir = n_ir; m_count = n_count; m_halted = n_halt;
        m_alu_out = alu_result; m_mdr = mem_data;
    endtask

    task automatic check_all();
        logic [31:0] sx;
        sx = (m_ir & 32'h0000_8000) != 32'd0 ? ((m_ir & 32'h0000_FFFF) | 32'hFFFF_0000)
                                              : (m_ir & 32'h0000_FFFF);
        check("pc", pc, m_pc);
        check("ir", ir, m_ir);
        check("opcode", {26'd0, opcode}, m_ir >> 26);
        check("rs", {27'd0, rs}, (m_ir >> 21) % 32'd32);
        check("rt", {27'd0, rt}, (m_ir >> 16) % 32'd32);
        check("rd", {27'd0, rd}, (m_ir >> 11) % 32'd32);
        check("funct", {26'd0, funct}, m_ir % 32'd64);
        check("imm_sext", imm_sext, sx);
        check("mdr", mdr, m_mdr);
        check("alu_out", alu_out, m_alu_out);
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        check("instr_count", instr_count, m_count);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    task automatic idle();
        PCWrite = 1'b0; PCWriteCond = 1'b0; IRWrite = 1'b0; zero = 1'b0;
        PCSource = 2'b11;
    endtask

    // Reset pulse wholly between two edges, checked before the next edge
    task automatic async_reset();
        cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_pc", pc, 32'h0);
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        alu_result = 32'h0; mem_data = 32'h0;
        #2;
        model_reset();
        check_all();
        #10 rst = 1'b0;

        // Fetch
        PCWrite = 1'b1; IRWrite = 1'b1; PCSource = 2'b00;
        alu_result = 32'd4; mem_data = 32'h8C01_0004;
        cycle();
        check("fetch_pc", pc, 32'd4);
        check("fetch_ir", ir, 32'h8C01_0004);
        check("fetch_op", {26'd0, opcode}, 32'h23);
        check("fetch_cnt", instr_count, 32'd1);

        // Branch via ALUOut
        idle(); alu_result = 32'h40;
        cycle();
        PCWriteCond = 1'b1; PCSource = 2'b01; zero = 1'b0;
        cycle();
        check("br_nt_pc", pc, 32'd4);
        zero = 1'b1;
        cycle();
        check("br_t_pc", pc, 32'h40);

        // Jump, then jump with simultaneous IR load
        idle(); PCWrite = 1'b1; PCSource = 2'b00; alu_result = 32'h1000_0008;
        IRWrite = 1'b1; mem_data = 32'h0800_0010;
        cycle();
        PCSource = 2'b10; mem_data = 32'h0800_0020;
        cycle();
        check("jmp_pc", pc, 32'h1000_0040);
        check("jmp_ir", ir, 32'h0800_0020);
        IRWrite = 1'b0;
        cycle();
        check("jmp2_pc", pc, 32'h1000_0080);

        // Halt
        idle(); IRWrite = 1'b1; mem_data = 32'hFC00_0000;
        cycle();
        idle();
        cycle();
        check("halt_set", {31'd0, halted}, 32'd1);
        PCWrite = 1'b1; IRWrite = 1'b1; PCSource = 2'b00;
        alu_result = 32'h100; mem_data = 32'h1234_5678;
        cycle();
        cycle();
        check("halt_pc", pc, 32'h1000_0080);
        check("halt_ir", ir, 32'hFC00_0000);
        check("halt_cnt", instr_count, 32'd4);
        check("halt_aluout", alu_out, 32'h100);

        // Asynchronous reset while halted
        async_reset();
        check("rst_halt", {31'd0, halted}, 32'd0);

        // Misaligned write
        idle(); PCWrite = 1'b1; PCSource = 2'b00; alu_result = 32'h6;
        cycle();
        check("mis_pc", pc, 32'h0);
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        alu_result = 32'h8;
        cycle();
        check("mis_hold", pc, 32'h0);

        // Randomized blocks, each starting from a mid-cycle reset
        for (int b = 0; b < 8; b++) begin
            idle();
            async_reset();
            for (int c = 0; c < 40; c++) begin
                logic [31:0] r;
                PCWrite     = ($urandom_range(0, 2) == 0);
                PCWriteCond = $urandom_range(0, 1) != 0;
                IRWrite     = $urandom_range(0, 1) != 0;
                zero        = $urandom_range(0, 1) != 0;
                PCSource    = 2'($urandom_range(0, 3));
                r = $urandom;
                if ($urandom_range(0, 15) != 0) r = r & 32'hFFFF_FFFC;
                alu_result = r;
                r = $urandom;
                if ((r >> 26) == 32'd63 && $urandom_range(0, 3) != 0) r = r & 32'h03FF_FFFF;
                mem_data = r;
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
